regfile_arbiter: RTL

- Sequences and shares one single-port register file between two requesters (port 0, port 1).
- Uses round-robin arbitration, one transaction at a time.
- Drives the register file's write/read strobes, address and write data, then returns read data with a valid pulse.
- Sits between the register file and its two client blocks.

---
 rtl/regfile_arbiter_pkg.sv | 17 +
 rtl/regfile_arbiter_if.sv | 36 +++
 rtl/regfile_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/regfile_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the two-port register file arbiter.
// Optional REGFILE_ARB_CLEAR_EN adds the bulk-clear state.
package regfile_arb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_MEM_DEPTH  = 8;

  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;

`ifdef REGFILE_ARB_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StAccess, StRwait, StClear} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StRwait} state_e;
`endif

endpackage

// File: rtl/regfile_arbiter_if.sv
// Client-side bus of the register file arbiter: two request ports plus shared read data.
interface regfile_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEFAULT_MEM_DEPTH)
) ();

  logic                  REQ0;
  logic                  REQ1;
  logic                  WE0;
  logic                  WE1;
  logic [ADDR_WIDTH-1:0] ADDR0;
  logic [ADDR_WIDTH-1:0] ADDR1;
  logic [DATA_WIDTH-1:0] WDATA0;
  logic [DATA_WIDTH-1:0] WDATA1;
  logic                  GNT0;
  logic                  GNT1;
  logic                  WACK0;
  logic                  WACK1;
  logic                  RVALID0;
  logic                  RVALID1;
  logic [DATA_WIDTH-1:0] RDATA;

  // Clients drive requests; the arbiter answers.
  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    input  GNT0, GNT1, WACK0, WACK1, RVALID0, RVALID1, RDATA
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    output GNT0, GNT1, WACK0, WACK1, RVALID0, RVALID1, RDATA
  );

endinterface

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer flips to the loser on every load.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic       LOAD,
  output logic [1:0] WINNER
);

  // prio_q names the port that wins a tie.
  logic prio_q, prio_d;

  always_comb begin
    WINNER = 2'b00;
    unique case (REQ)
      2'b01:   WINNER = 2'b01;
      2'b10:   WINNER = 2'b10;
      2'b11:   WINNER = prio_q ? 2'b10 : 2'b01;
      default: WINNER = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (LOAD && (|REQ)) begin
      prio_d = WINNER[PORT0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one single-port register file between two clients, one transaction at a time.
// Define REGFILE_ARB_CLEAR_EN to add the CLR_REQ/CLR_DONE bulk-clear sequence.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned  MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_arbiter_if.slave      bus,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA
`ifdef REGFILE_ARB_CLEAR_EN
  ,
  input  logic                  CLR_REQ,
  output logic                  CLR_DONE
`endif
);

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            wack_q, wack_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
`ifdef REGFILE_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_done_q, clr_done_d;
`endif

  logic [1:0] req;
  logic [1:0] winner;
  logic       grant_load;

  assign req = {bus.REQ1, bus.REQ0};

  // A pending clear pre-empts client requests, so the pointer must not move then.
`ifdef REGFILE_ARB_CLEAR_EN
  assign grant_load = (state_q == StIdle) && (|req) && !CLR_REQ;
`else
  assign grant_load = (state_q == StIdle) && (|req);
`endif

  rr_arbiter2 u_rr_arbiter2 (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (req),
    .LOAD   (grant_load),
    .WINNER (winner)
  );

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    gnt_d        = 2'b00;
    wack_d       = 2'b00;
    rvalid_d     = 2'b00;
    rdata_d      = rdata_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
`ifdef REGFILE_ARB_CLEAR_EN
    cnt_d        = cnt_q;
    clr_done_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef REGFILE_ARB_CLEAR_EN
        if (CLR_REQ) begin
          state_d      = StClear;
          cnt_d        = '0;
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = '0;
          rf_wr_data_d = '0;
        end else
`endif
        if (|req) begin
          state_d = StAccess;
          gnt_d   = winner;
          if (winner[PORT1]) begin
            port_d       = 1'b1;
            we_d         = bus.WE1;
            rf_addr_d    = bus.ADDR1;
            rf_wr_data_d = bus.WDATA1;
          end else begin
            port_d       = 1'b0;
            we_d         = bus.WE0;
            rf_addr_d    = bus.ADDR0;
            rf_wr_data_d = bus.WDATA0;
          end
          rf_wr_en_d = we_d;
          rf_rd_en_d = ~we_d;
        end
      end

      StAccess: begin
        if (we_q) begin
          wack_d[port_q] = 1'b1;
          state_d        = StIdle;
        end else begin
          state_d = StRwait;
        end
      end

      // Register file read data is valid one cycle after the read strobe.
      StRwait: begin
        rdata_d          = RF_RD_DATA;
        rvalid_d[port_q] = 1'b1;
        state_d          = StIdle;
      end

`ifdef REGFILE_ARB_CLEAR_EN
      StClear: begin
        if (cnt_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          clr_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = cnt_q + 1'b1;
          rf_wr_data_d = '0;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      gnt_q        <= 2'b00;
      wack_q       <= 2'b00;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
`ifdef REGFILE_ARB_CLEAR_EN
      cnt_q        <= '0;
      clr_done_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      gnt_q        <= gnt_d;
      wack_q       <= wack_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
`ifdef REGFILE_ARB_CLEAR_EN
      cnt_q        <= cnt_d;
      clr_done_q   <= clr_done_d;
`endif
    end
  end

  assign bus.GNT0    = gnt_q[PORT0];
  assign bus.GNT1    = gnt_q[PORT1];
  assign bus.WACK0   = wack_q[PORT0];
  assign bus.WACK1   = wack_q[PORT1];
  assign bus.RVALID0 = rvalid_q[PORT0];
  assign bus.RVALID1 = rvalid_q[PORT1];
  assign bus.RDATA   = rdata_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_DATA  = rf_wr_data_q;
`ifdef REGFILE_ARB_CLEAR_EN
  assign CLR_DONE    = clr_done_q;
`endif

endmodule
